// File: rtl/vga_bus_target.sv
// Bus-side target for the Amiga-to-VGA bridge: index/data register file,
// pointer-addressed memory window with req/ack handshake, and WAIT ready control.
module vga_bus_target #(
   parameter int MEM_AW    = 16,
   parameter int REG_COUNT = 16,
   parameter int WAIT_MIN  = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              BALE,
   input  logic              IOR,
   input  logic              IOW,
   input  logic              MEMR,
   input  logic              MEMW,
   input  logic              SA0,
   input  logic              SA12,
   inout  wire  [15:0]       DG,
   output logic              WAIT,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        cfg
);

   localparam int RIW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int LW  = $clog2(WAIT_MIN + 1) + 1;

   typedef enum logic [2:0] {IDLE, IO_HOLD, MEM_REQ, MEM_HOLD, RELEASE} state_t;
   // Encoding doubles as the bit position of the strobe in s_str/p_str.
   typedef enum logic [1:0] {CMD_IOR, CMD_IOW, CMD_MEMR, CMD_MEMW} cmd_t;

   state_t            state;
   cmd_t              cmd, cmd_sel;
   logic [3:0]        s_str, p_str;
   logic              s_bale;
   logic              cmd_valid;
   logic [7:0]        index;
   logic [7:0]        regs [REG_COUNT];
   logic [MEM_AW-1:0] pointer;
   logic [15:0]       ptr16, ptr_wr16;
   logic [7:0]        rd_byte;
   logic [15:0]       rdata;
   logic              sa12_q, timed_out;
   logic [TW-1:0]     to_cnt;
   logic [LW-1:0]     low_cnt;
   logic              dg_oe;
   logic [15:0]       dg_out;

   assign ptr16 = 16'(pointer);
   assign cfg   = regs[3];

   // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      cmd_sel   = CMD_IOR;
      cmd_valid = !s_bale && $onehot(~s_str) && |(p_str & ~s_str);
      if (!s_str[CMD_IOW])       cmd_sel = CMD_IOW;
      else if (!s_str[CMD_MEMR]) cmd_sel = CMD_MEMR;
      else if (!s_str[CMD_MEMW]) cmd_sel = CMD_MEMW;

      rd_byte = 8'hFF;
      if (int'(index) < REG_COUNT) begin
         case (index)
            8'd0:    rd_byte = ptr16[7:0];
            8'd1:    rd_byte = ptr16[15:8];
            default: rd_byte = regs[index[RIW-1:0]];
         endcase
      end

      ptr_wr16 = ptr16;
      if (index == 8'd1) ptr_wr16[15:8] = DG[7:0];
      else               ptr_wr16[7:0]  = DG[7:0];
   end

   // Read data is released as soon as the raw strobe rises, not a cycle later.
   assign dg_oe  = (state == IO_HOLD  && cmd == CMD_IOR  && !IOR) ||
                   (state == MEM_HOLD && cmd == CMD_MEMR && !MEMR);
   assign dg_out = (state == IO_HOLD) ? {8'hFF, rd_byte} : rdata;
   assign DG     = dg_oe ? dg_out : 16'bz;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge mclk) begin
      if (reset) begin
         state     <= IDLE;
         cmd       <= CMD_IOR;
         s_str     <= 4'b1111;
         p_str     <= 4'b1111;
         s_bale    <= 1'b1;
         WAIT      <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= '0;
         index     <= '0;
         pointer   <= '0;
         rdata     <= '0;
         sa12_q    <= 1'b0;
         timed_out <= 1'b0;
         to_cnt    <= '0;
         low_cnt   <= '0;
         // NOTE: the register file is small and its cleared state is architecturally visible, so it is reset.
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         s_str  <= {MEMW, MEMR, IOW, IOR};
         p_str  <= s_str;
         s_bale <= BALE;

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd <= cmd_sel;
                  if (cmd_sel == CMD_IOR || cmd_sel == CMD_IOW) begin
                     state <= IO_HOLD;
                     if (cmd_sel == CMD_IOW) begin
                        if (!SA0)                             index <= DG[7:0];
                        else if (index == 8'd0 || index == 8'd1) pointer <= MEM_AW'(ptr_wr16);
                        else if (int'(index) < REG_COUNT)     regs[index[RIW-1:0]] <= DG[7:0];
                     end
                  end else begin
                     state     <= MEM_REQ;
                     WAIT      <= 1'b0;
                     mem_req   <= 1'b1;
                     mem_addr  <= pointer;
                     mem_be    <= SA0 ? 2'b01 : 2'b11;
                     mem_we    <= (cmd_sel == CMD_MEMW);
                     sa12_q    <= SA12;
                     timed_out <= 1'b0;
                     to_cnt    <= '0;
                     low_cnt   <= '0;
                     if (cmd_sel == CMD_MEMW) mem_wdata <= DG;
                  end
               end
            end

            IO_HOLD: if (s_str[cmd]) state <= RELEASE;

            MEM_REQ: begin
               if (int'(low_cnt) < WAIT_MIN) low_cnt <= low_cnt + LW'(1);
               if (mem_ack || to_cnt == TW'(TIMEOUT - 1)) begin
                  mem_req   <= 1'b0;
                  rdata     <= mem_ack ? mem_rdata : 16'hFFFF;
                  timed_out <= !mem_ack;
                  // A strobe that already went away skips the minimum-WAIT rule.
                  if (s_str[cmd]) begin
                     WAIT  <= 1'b1;
                     state <= RELEASE;
                  end else begin
                     state <= MEM_HOLD;
                  end
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end

            MEM_HOLD: begin
               if (int'(low_cnt) < WAIT_MIN) low_cnt <= low_cnt + LW'(1);
               if (int'(low_cnt) + 1 >= WAIT_MIN) WAIT <= 1'b1;
               if (s_str[cmd]) begin
                  WAIT  <= 1'b1;
                  state <= RELEASE;
               end
            end

            RELEASE: begin
               if ((cmd == CMD_MEMR || cmd == CMD_MEMW) && sa12_q && !timed_out)
                  pointer <= pointer + MEM_AW'(1);
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_bus_target.sv
// Scoreboard bench for vga_bus_target: stimulus queues expected memory requests
// and WAIT-low lengths; a negedge monitor pops and compares them as the DUT produces them.
module tb_vga_bus_target;

   logic        mclk = 1'b0;
   logic        reset, BALE, IOR, IOW, MEMR, MEMW, SA0, SA12;
   logic        WAIT, mem_req, mem_we, mem_ack;
   logic [1:0]  mem_be;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  cfg;
   logic [15:0] tb_dg;
   logic        tb_oe;
   logic        mon_en = 1'b0;
   wire  [15:0] DG;

   int n_vec = 0;
   int n_err = 0;

   // Undriven DG reads as 0x0000, which stands for "released" in the checks below.
   for (genvar i = 0; i < 16; i++) begin : g_pd
      pulldown pd (DG[i]);
   end
   assign DG = tb_oe ? tb_dg : 16'bz;

   always #5 mclk = ~mclk;

   vga_bus_target dut (
      .mclk(mclk), .reset(reset), .BALE(BALE), .IOR(IOR), .IOW(IOW),
      .MEMR(MEMR), .MEMW(MEMW), .SA0(SA0), .SA12(SA12), .DG(DG),
      .WAIT(WAIT), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .cfg(cfg)
   );

   typedef struct {
      logic        we;
      logic [1:0]  be;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          high;
   } req_t;

   req_t req_q[$];
   int   wait_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever mem_req rises or WAIT returns high.
   initial begin
      logic prev_req, prev_wait;
      int   rc, wc, cur_high;
      req_t cur;
      prev_req = 1'b0; prev_wait = 1'b1; rc = 0; wc = 0; cur_high = 0;
      wait (mon_en);
      forever begin
         @(negedge mclk);
         if (mem_req && !prev_req) begin
            rc = 1;
            check("req_expected", 32'(req_q.size() > 0), 1);
            if (req_q.size() > 0) begin
               cur = req_q.pop_front();
               cur_high = cur.high;
               check("req_we",   32'(mem_we),   32'(cur.we));
               check("req_be",   32'(mem_be),   32'(cur.be));
               check("req_addr", 32'(mem_addr), 32'(cur.addr));
               if (cur.we) check("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
            end
         end else if (mem_req) begin
            rc++;
         end
         if (!mem_req && prev_req) check("req_high_cycles", rc, cur_high);

         if (!WAIT) wc = prev_wait ? 1 : wc + 1;
         if (WAIT && !prev_wait) begin
            check("wait_expected", 32'(wait_q.size() > 0), 1);
            if (wait_q.size() > 0) check("wait_low_cycles", wc, wait_q.pop_front());
         end
         prev_req  = mem_req;
         prev_wait = WAIT;
      end
   end

   task automatic io_write(input logic sa0, input logic [15:0] d);
      @(posedge mclk); #2;
      BALE = 1'b0; SA0 = sa0; tb_dg = d; tb_oe = 1'b1; IOW = 1'b0;
      repeat (4) @(posedge mclk);
      #2 IOW = 1'b1;
      @(posedge mclk); #2;
      BALE = 1'b1; tb_oe = 1'b0;
      repeat (3) @(posedge mclk);
   endtask

   task automatic io_read(input logic sa0, input logic [15:0] exp, input string name);
      @(posedge mclk); #2;
      BALE = 1'b0; SA0 = sa0; IOR = 1'b0;
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      check(name, 32'(DG), 32'(exp));
      #1 IOR = 1'b1;
      #1 check({name, "_release"}, 32'(DG), 0);
      @(posedge mclk); #2 BALE = 1'b1;
      repeat (3) @(posedge mclk);
   endtask

   // ack_d < 0 means the memory never acknowledges.
   task automatic mem_access(input logic wr, input logic sa0, input logic sa12,
                             input logic [15:0] wd, input int ack_d, input logic [15:0] rd,
                             input logic [1:0] exp_be, input logic [15:0] exp_addr,
                             input int exp_high, input int exp_low,
                             input logic [15:0] exp_dg, input string name);
      req_t r;
      logic got;
      int   n;
      r.we = wr; r.be = exp_be; r.addr = exp_addr; r.wdata = wd; r.high = exp_high;
      req_q.push_back(r);
      wait_q.push_back(exp_low);
      @(posedge mclk); #2;
      BALE = 1'b0; SA0 = sa0; SA12 = sa12;
      if (wr) begin tb_dg = wd; tb_oe = 1'b1; MEMW = 1'b0; end
      else    MEMR = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge mclk);
         got = mem_req;
      end
      check({name, "_req_seen"}, 32'(got), 1);
      if (got && ack_d >= 0) begin
         repeat (ack_d) @(negedge mclk);
         mem_rdata = rd; mem_ack = 1'b1;
         @(negedge mclk);
         mem_ack = 1'b0;
      end
      n = 0;
      while (!WAIT && n < 400) begin
         @(negedge mclk);
         n++;
      end
      check({name, "_wait_high"}, 32'(WAIT), 1);
      if (!wr) check({name, "_dg"}, 32'(DG), 32'(exp_dg));
      #1 MEMR = 1'b1; MEMW = 1'b1;
      #1 check({name, "_dg_release"}, 32'(DG), 32'(wr ? wd : 16'h0000));
      @(posedge mclk); #2;
      BALE = 1'b1; tb_oe = 1'b0;
      repeat (3) @(posedge mclk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; BALE = 1'b1; IOR = 1'b1; IOW = 1'b1; MEMR = 1'b1; MEMW = 1'b1;
      SA0 = 1'b0; SA12 = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
      tb_dg = 16'h0000; tb_oe = 1'b0;
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      check("rst_wait",      32'(WAIT),      1);
      check("rst_mem_req",   32'(mem_req),   0);
      check("rst_mem_we",    32'(mem_we),    0);
      check("rst_mem_be",    32'(mem_be),    0);
      check("rst_mem_addr",  32'(mem_addr),  0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cfg",       32'(cfg),       0);
      check("rst_dg",        32'(DG),        0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Index/data register access and pointer readback.
      io_write(1'b0, 16'h0001);
      io_write(1'b1, 16'h0034);
      io_read(1'b1, 16'hFF34, "reg1_read");
      io_write(1'b0, 16'h0000);
      io_read(1'b1, 16'hFF00, "reg0_read");

      // Word write with post-increment, ack on the fourth request cycle.
      io_write(1'b1, 16'h0010);
      io_write(1'b0, 16'h0001);
      io_write(1'b1, 16'h0000);
      mem_access(1'b1, 1'b0, 1'b1, 16'hBEEF, 3, 16'h0000, 2'b11, 16'h0010, 4, 5,
                 16'h0000, "memw_word");
      io_write(1'b0, 16'h0000);
      io_read(1'b1, 16'hFF11, "ptr_after_inc");

      // Byte read, immediate ack, no increment.
      mem_access(1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h1234, 2'b01, 16'h0011, 1, 2,
                 16'h1234, "memr_byte");
      io_read(1'b1, 16'hFF11, "ptr_no_inc");

      // Read with no ack times out; pointer is held even with SA12=1.
      mem_access(1'b0, 1'b0, 1'b1, 16'h0000, -1, 16'h0000, 2'b11, 16'h0011, 255, 256,
                 16'hFFFF, "memr_timeout");
      io_read(1'b1, 16'hFF11, "ptr_after_timeout");

      // Pointer wraps from 0xFFFF to 0x0000.
      io_write(1'b1, 16'h00FF);
      io_write(1'b0, 16'h0001);
      io_write(1'b1, 16'h00FF);
      mem_access(1'b1, 1'b0, 1'b1, 16'h0A0A, 1, 16'h0000, 2'b11, 16'hFFFF, 2, 3,
                 16'h0000, "memw_wrap");
      io_read(1'b1, 16'hFF00, "ptr_hi_wrapped");
      io_write(1'b0, 16'h0000);
      io_read(1'b1, 16'hFF00, "ptr_lo_wrapped");

      // Out-of-range index reads all ones.
      io_write(1'b0, 16'h0020);
      io_read(1'b1, 16'hFFFF, "index_out_of_range");

      // Register 3 drives cfg.
      io_write(1'b0, 16'h0003);
      io_write(1'b1, 16'h005A);
      check("cfg_written", 32'(cfg), 32'h5A);
      io_read(1'b1, 16'hFF5A, "reg3_read");

      // Two strobes low together: no command.
      @(posedge mclk); #2;
      BALE = 1'b0; IOR = 1'b0; MEMR = 1'b0;
      repeat (5) @(negedge mclk);
      check("dual_strobe_mem_req", 32'(mem_req), 0);
      check("dual_strobe_dg",      32'(DG),      0);
      check("dual_strobe_wait",    32'(WAIT),    1);
      IOR = 1'b1; MEMR = 1'b1;
      @(posedge mclk); #2 BALE = 1'b1;
      repeat (3) @(posedge mclk);

      // Reset while a request is outstanding, then a stale ack.
      req_q.push_back('{we: 1'b0, be: 2'b11, addr: 16'h0000, wdata: 16'h0000, high: 1});
      wait_q.push_back(1);
      @(posedge mclk); #2;
      BALE = 1'b0; SA0 = 1'b0; SA12 = 1'b1; MEMR = 1'b0;
      begin
         logic got;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge mclk);
            got = mem_req;
         end
         check("rstreq_req_seen", 32'(got), 1);
      end
      reset = 1'b1;
      @(negedge mclk);
      check("rstreq_wait",    32'(WAIT),    1);
      check("rstreq_mem_req", 32'(mem_req), 0);
      check("rstreq_mem_we",  32'(mem_we),  0);
      check("rstreq_dg",      32'(DG),      0);
      check("rstreq_cfg",     32'(cfg),     0);
      reset = 1'b0; MEMR = 1'b1; BALE = 1'b1;
      @(negedge mclk);
      mem_rdata = 16'h5555; mem_ack = 1'b1;
      @(negedge mclk);
      mem_ack = 1'b0;
      repeat (3) @(negedge mclk);
      check("stale_ack_mem_req", 32'(mem_req), 0);
      check("stale_ack_wait",    32'(WAIT),    1);
      io_read(1'b1, 16'hFF00, "ptr_after_reset");
      io_write(1'b0, 16'h0003);
      io_read(1'b1, 16'hFF00, "reg3_after_reset");

      repeat (5) @(posedge mclk);
      check("req_queue_drained",  32'(req_q.size()),  0);
      check("wait_queue_drained", 32'(wait_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_bus_target.md
Name: vga_bus_target

Overview:
- Responder on the 16-bit VGA-side bus that the Amiga bridge drives (BALE, IOR/IOW, MEMR/MEMW, SA0, SA12, DG, WAIT).
- Provides an index/data I/O register file, a memory data window backed by an external word memory through a req/ack handshake, and the WAIT ready-handshake the bridge samples.
- Used as the on-card target for bridge bring-up and as the bus end of a CPLD/FPGA framebuffer replacement.

Parameters:
- MEM_AW, 16, word-address width of the memory window pointer and mem_addr.
- REG_COUNT, 16, number of implemented 8-bit index registers (≤256).
- WAIT_MIN, 2, minimum cycles WAIT is held 0 on a memory access.
- TIMEOUT, 255, cycles without mem_ack before a memory access aborts.

Ports:
- mclk  in  1  bus clock; command strobes are generated synchronously to it.
- reset  in  1  synchronous, active-high reset.
- BALE  in  1  active-low cycle envelope; commands accepted only while 0.
- IOR, IOW, MEMR, MEMW  in  1 each  active-low command strobes.
- SA0  in  1  I/O: 0=index port, 1=data port; memory: 0=word (be=11), 1=low byte only (be=01).
- SA12  in  1  memory: 1=post-increment pointer, 0=no increment; ignored on I/O.
- DG  inout  16  data bus; Z unless this block is driving read data.
- WAIT  out  1  1=ready, 0=hold.
- mem_req  out  1  memory request level.
- mem_we  out  1  1=write.
- mem_be  out  2  byte enables.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle completion pulse.
- cfg  out  8  contents of register 3.

Behaviour:
- Reset (sync, any state): state=IDLE; WAIT=1; mem_req=0; mem_we=0; mem_be=00; mem_addr=0; mem_wdata=0; DG=Z; index=0; all registers=0; pointer=0; cfg=0.
- Strobes are registered once (s_*). A command is a 1→0 transition of exactly one registered strobe while registered BALE=0. If two or more strobes are low together, no command is accepted and the block stays IDLE.
- Registers: reg0=pointer[7:0], reg1=pointer[15:8] (only bits below MEM_AW are used), reg3=cfg, others general purpose.
- Register writes take effect at the edge where the command is detected. The pointer reads back its live value.
- FSM states: IDLE, IO_HOLD, MEM_REQ, MEM_HOLD, RELEASE.
- IDLE→IO_HOLD on an I/O command. WAIT stays 1 for I/O.
  - IOW, SA0=0: index←DG[7:0].
  - IOW, SA0=1: reg[index]←DG[7:0]; the write is ignored if index≥REG_COUNT.
  - IOR: DG={8'hFF, reg[index] or 8'hFF if index≥REG_COUNT}, driven while IOR (raw) is 0 and state is IO_HOLD.
  - The index does not auto-increment.
- IDLE→MEM_REQ on a memory command, at the detect edge:
  - WAIT←0; mem_req←1; mem_addr←pointer; mem_be from SA0; mem_we←(MEMW); mem_wdata←DG (writes); latch SA12 and the command type.
  - This edge is the second rising edge after the strobe falls. The bridge samples WAIT no earlier than the third.
- MEM_REQ: outputs held stable until mem_ack=1.
  - On ack: mem_req←0, rdata←mem_rdata (reads), go to MEM_HOLD.
  - A timeout counter counts cycles in MEM_REQ. When it reaches TIMEOUT: mem_req←0, rdata←16'hFFFF, go to MEM_HOLD, pointer is not incremented.
- MEM_HOLD: WAIT←1 once both conditions hold: at least WAIT_MIN cycles since WAIT fell, and the ack/timeout has happened. An ack in the same cycle as the request still gives WAIT_MIN cycles low. For reads, DG=rdata is driven while MEMR (raw) is 0.
- IO_HOLD/MEM_HOLD→RELEASE when the registered active strobe returns to 1. DG is released to Z combinationally as the raw strobe rises.
- RELEASE: if the access was a memory access, SA12 was latched 1 and it did not time out, pointer←pointer+1 mod 2^MEM_AW. Then →IDLE. The state occupies one cycle, so back-to-back commands are spaced ≥1 cycle.
- Strobe deasserted before ack (protocol violation): stay in MEM_REQ until ack/timeout. WAIT goes 1 in the same cycle as the ack/timeout rather than waiting for the normal MEM_HOLD rule, then →RELEASE.
- BALE rising during a cycle is ignored. Only the strobe ends a cycle.
- mem_ack outside MEM_REQ is ignored.

Test Plan:
- IOW SA0=0 DG=0x0001, then IOW SA0=1 DG=0x0034, then IOR SA0=1 → DG=0xFF34; pointer=0x3400; WAIT never 0.
- Pointer=0x0010; MEMW SA12=1 SA0=0 DG=0xBEEF; ack 4 cycles after mem_req → mem_req/mem_we=1, mem_addr=0x0010, mem_be=11, mem_wdata=0xBEEF; WAIT 0 from the detect edge until the edge after ack; pointer=0x0011 after release.
- MEMR SA12=0 SA0=1; ack in the first request cycle with mem_rdata=0x1234 → mem_be=01; WAIT low exactly WAIT_MIN=2 cycles; DG=0x1234 while MEMR=0, Z after; pointer unchanged.
- MEMR with no ack → mem_req drops after 255 cycles; WAIT=1; DG=0xFFFF; pointer not incremented.
- Pointer=0xFFFF, MEMW SA12=1 acked → pointer=0x0000. IOR index=0x20 → DG=0xFFFF. IOR+MEMR low together → no mem_req, DG=Z.
- reset=1 during MEM_REQ → next edge: WAIT=1, mem_req=0, DG=Z, cfg=0, state IDLE; a stale ack afterwards is ignored.
